// File: rtl/ex_mem_if.sv
// EX -> MEM pipeline bus: EX-side valid/ready/flush plus instruction fields,
// and the MEM-side head view with its consume strobe.
interface ex_mem_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int WB_W   = 2
);
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [WB_W-1:0]   ctlwb_in;
  logic [2:0]        ctlm_in;
  logic [DATA_W-1:0] add_in;
  logic              zero_in;
  logic [DATA_W-1:0] alu_in;
  logic [DATA_W-1:0] rdata2_in;
  logic [REG_AW-1:0] dst_in;

  logic              out_valid;
  logic              out_ready;
  logic [WB_W-1:0]   wb_ctlout;
  logic              branch;
  logic              memread;
  logic              memwrite;
  logic              pcsrc;
  logic [DATA_W-1:0] add_result;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] rdata2out;
  logic              zero;
  logic [REG_AW-1:0] dst_out;
  logic [1:0]        occupancy;

  // master: the pipeline environment (EX producer and MEM consumer)
  modport master (
    output in_valid, flush, ctlwb_in, ctlm_in, add_in, zero_in, alu_in,
           rdata2_in, dst_in, out_ready,
    input  in_ready, out_valid, wb_ctlout, branch, memread, memwrite, pcsrc,
           add_result, alu_result, rdata2out, zero, dst_out, occupancy
  );

  // slave: the EX/MEM stage itself
  modport slave (
    input  in_valid, flush, ctlwb_in, ctlm_in, add_in, zero_in, alu_in,
           rdata2_in, dst_in, out_ready,
    output in_ready, out_valid, wb_ctlout, branch, memread, memwrite, pcsrc,
           add_result, alu_result, rdata2out, zero, dst_out, occupancy
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush-to-bubble and a branch-taken decision captured alongside each entry.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int WB_W   = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  ex_mem_if.slave  bus
);

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic              branch;
    logic              memread;
    logic              memwrite;
    logic              taken;
    logic              zero;
    logic [DATA_W-1:0] add;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata2;
    logic [REG_AW-1:0] dst;
  } entry_t;

  entry_t head_reg, head_next;
  entry_t skid_reg, skid_next;
  logic   head_valid_reg, head_valid_next;
  logic   skid_valid_reg, skid_valid_next;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  always_comb begin
    in_entry          = '0;
    in_entry.wb       = bus.ctlwb_in;
    in_entry.branch   = bus.ctlm_in[2];
    in_entry.memread  = bus.ctlm_in[1];
    in_entry.memwrite = bus.ctlm_in[0];
    in_entry.taken    = bus.ctlm_in[2] & bus.zero_in;
    in_entry.zero     = bus.zero_in;
    in_entry.add      = bus.add_in;
    in_entry.alu      = bus.alu_in;
    in_entry.rdata2   = bus.rdata2_in;
    in_entry.dst      = bus.dst_in;
  end

  // Ready depends only on registered state, so out_ready never reaches in_ready.
  assign accept = bus.in_valid & ~skid_valid_reg;
  assign pop    = head_valid_reg & bus.out_ready;

  always_comb begin
    head_next       = head_reg;
    skid_next       = skid_reg;
    head_valid_next = head_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (bus.flush) begin
      // Data is left stale; only the valid bits matter and the input is dropped.
      head_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (skid_valid_reg) begin
      if (pop) begin
        head_next       = skid_reg;
        skid_valid_next = 1'b0;
      end
    end else if (head_valid_reg) begin
      if (pop && accept) begin
        head_next = in_entry;
      end else if (pop) begin
        head_valid_next = 1'b0;
      end else if (accept) begin
        skid_next       = in_entry;
        skid_valid_next = 1'b1;
      end
    end else if (accept) begin
      head_next       = in_entry;
      head_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg       <= '0;
      skid_reg       <= '0;
      head_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      head_reg       <= head_next;
      skid_reg       <= skid_next;
      head_valid_reg <= head_valid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign bus.in_ready   = ~skid_valid_reg;
  assign bus.out_valid  = head_valid_reg;
  assign bus.occupancy  = skid_valid_reg ? 2'd2 : (head_valid_reg ? 2'd1 : 2'd0);

  // Control is forced to a bubble when empty; data fields are left stale.
  assign bus.wb_ctlout  = head_valid_reg ? head_reg.wb : '0;
  assign bus.branch     = head_valid_reg & head_reg.branch;
  assign bus.memread    = head_valid_reg & head_reg.memread;
  assign bus.memwrite   = head_valid_reg & head_reg.memwrite;
  assign bus.pcsrc      = head_valid_reg & head_reg.taken;
  assign bus.add_result = head_reg.add;
  assign bus.alu_result = head_reg.alu;
  assign bus.rdata2out  = head_reg.rdata2;
  assign bus.zero       = head_reg.zero;
  assign bus.dst_out    = head_reg.dst;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX/MEM pipeline stage between the execute stage and data-memory access.
- Replaces the combinational, delay-modelled EX/MEM latch with a true clocked register.
- Adds a valid/ready handshake, a 2-entry skid buffer for MEM-side stalls, flush-to-bubble, and a registered branch-taken (PCSrc) decision.

Parameters:
- DATA_W, 32: width of ALU result, store data and branch target.
- REG_AW, 5: width of destination register address.
- WB_W, 2: width of write-back control field (RegWrite, MemtoReg).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- flush  in  1  squash all held and incoming instructions
- ctlwb_in  in  WB_W  write-back control
- ctlm_in  in  3  [2]=branch, [1]=memread, [0]=memwrite
- add_in  in  DATA_W  branch target address
- zero_in  in  1  ALU zero flag
- alu_in  in  DATA_W  ALU result
- rdata2_in  in  DATA_W  store data
- dst_in  in  REG_AW  destination register
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM consumes head this cycle
- wb_ctlout  out  WB_W  head write-back control, gated
- branch, memread, memwrite  out  1 each  head memory control, gated
- pcsrc  out  1  head branch & zero, gated
- add_result, alu_result, rdata2out  out  DATA_W  head data
- zero  out  1  head zero flag
- dst_out  out  REG_AW  head destination register
- occupancy  out  2  entries held (0..2)

Behaviour:
- One clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - Both entries are invalid and all stored fields are 0.
  - out_valid=0, occupancy=0, in_ready=1, and every output reads 0.
- Storage: a head register (drives outputs) and a skid register.
- Each entry stores all input fields plus a taken bit, computed at capture as ctlm_in[2] & zero_in.
- in_ready = !skid_valid. It is a pure function of registered state and has no combinational path from out_ready.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Per clock edge, no flush:
  - Head empty (occupancy 0), accept: capture into head. Occupancy becomes 1, out_valid=1 next cycle (latency 1).
  - Head valid, skid empty:
    - pop & accept: head takes the input. Occupancy stays 1.
    - pop only: head is emptied.
    - accept only: input goes to skid. Occupancy becomes 2 and in_ready becomes 0 next cycle.
  - Skid valid (full, occupancy 2):
    - pop: skid moves to head. Occupancy becomes 1.
    - no pop: hold.
    - No accept is possible in this state.
- Ordering is strictly FIFO. No entry is duplicated or dropped.
- Flush has priority over everything:
  - Both entries are invalidated and occupancy becomes 0 on the next edge.
  - An input presented with flush is discarded, even if in_valid & in_ready.
  - A pop in the same cycle as flush still counts as consumed by MEM.
- Output gating:
  - When out_valid=0, the outputs wb_ctlout, branch, memread, memwrite and pcsrc are forced to 0 (bubble).
  - add_result, alu_result, rdata2out, zero and dst_out reflect the stale head contents; downstream must qualify them with out_valid.
- pcsrc = head.taken & out_valid, so a squashed branch never redirects the PC.
- Reset asserted mid-operation takes effect immediately (asynchronous) and discards all entries.
- Release of rst_n is synchronous to clk. The first accept can occur on the first edge after release.
- Data fields are passed through unchanged. The block does no arithmetic on data; widths follow the parameters.

Test Plan:
- Reset then single transfer:
  - Stimulus: rst_n low, all outputs checked 0. Release; in_valid=1, ctlwb=2'b11, ctlm=3'b010, alu=32'h0000_0040, dst=5'd8, out_ready=1.
  - Required: next cycle out_valid=1, memread=1, alu_result=32'h40, dst_out=8. One cycle later out_valid=0 and memread=0.
- Back-pressure fill:
  - Stimulus: out_ready=0; push A (alu=1), B (alu=2), C (alu=3) on consecutive cycles.
  - Required: A and B accepted, occupancy=2, in_ready=0, C held upstream. Raise out_ready: outputs A, B, C in order, no gaps after C is accepted.
- Branch decision:
  - Stimulus: ctlm=3'b100, zero=1, add=32'h0000_1000.
  - Required: pcsrc=1, add_result=32'h1000. Repeat with zero=0: pcsrc=0, branch=1.
- Flush with full buffer:
  - Stimulus: occupancy=2, assert flush together with in_valid=1.
  - Required: next cycle occupancy=0, out_valid=0, pcsrc=0, memwrite=0, in_ready=1. The flushed input never appears at the outputs.
- Asynchronous reset mid-stream:
  - Stimulus: occupancy=1 holding memwrite=1; pulse rst_n low between clock edges.
  - Required: memwrite and out_valid drop to 0 before the next edge.
- Parameter sweep:
  - Stimulus: DATA_W=64, REG_AW=6, alu=64'hDEAD_BEEF_0123_4567, dst=6'd63.
  - Required: values pass through bit-exact.
